// File: rtl/cmp_run_monitor.sv
// Run monitor behind the A/B equality comparator: counts consecutive
// equal samples, flags a run at RUN_LEN and hands it off via valid/ack.
module cmp_run_monitor #(
  parameter int W       = 2,
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic             ack,
  output logic             eq,
  output logic [CNT_W-1:0] run_cnt,
  output logic             hit,
  output logic             rpt_valid,
  output logic [W-1:0]     rpt_data,
  output logic [CNT_W-1:0] rpt_idx,
  output logic             ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DET_AT  = CNT_W'(RUN_LEN - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_sample_cnt;
  logic             w_match;
  logic             w_det;
  logic             w_load;

  assign w_match = (A == B);

  // DONE blocks re-firing while the run continues, including at saturation
  assign w_det  = en & w_match & (run_cnt == DET_AT) & (r_state != S_DONE);
  assign w_load = w_det & (~rpt_valid | ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sample_cnt <= '0;
      eq           <= 1'b0;
      run_cnt      <= '0;
      hit          <= 1'b0;
    end else begin
      hit <= w_det;
      if (en) begin
        eq           <= w_match;
        r_sample_cnt <= r_sample_cnt + 1'b1;
        if (!w_match) begin
          run_cnt <= '0;
          r_state <= S_IDLE;
        end else begin
          if (run_cnt != CNT_MAX)
            run_cnt <= run_cnt + 1'b1;
          if (w_det)
            r_state <= S_DONE;
          else if (r_state == S_IDLE)
            r_state <= S_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_valid <= 1'b0;
      rpt_data  <= '0;
      rpt_idx   <= '0;
      ovf       <= 1'b0;
    end else if (w_load) begin
      rpt_valid <= 1'b1;
      rpt_data  <= A;
      rpt_idx   <= r_sample_cnt;
    end else if (w_det) begin
      ovf <= 1'b1;
    end else if (rpt_valid && ack) begin
      rpt_valid <= 1'b0;
    end
  end

endmodule
